// File: rtl/mmc1_mapper.sv
// MMC1 (iNES mapper 1) bank controller.
// CPU writes to $8000-$FFFF feed a 5-bit LSB-first serial port. The fifth
// accepted bit loads one of four internal registers, and those registers
// steer PRG/CHR banking, nametable mirroring and the PRG-RAM enable.
module mmc1_mapper #(
  parameter int unsigned PRG_AW = 18,
  parameter int unsigned CHR_AW = 17
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic [14:0]       cpu_addr,
  input  logic [7:0]        cpu_data_i,
  input  logic              cpu_rw,
  input  logic              romsel,
  input  logic [13:0]       ppu_addr,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [CHR_AW-1:0] chr_addr,
  output logic              ciram_a10,
  output logic              prgram_en,
  output logic [19:0]       regs_dbg
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PRG_NAT = 18;
  localparam int unsigned CHR_NAT = 17;

  logic [REG_W-1:0] control;
  logic [REG_W-1:0] chr0;
  logic [REG_W-1:0] chr1;
  logic [REG_W-1:0] prg;
  logic [REG_W-1:0] shift;
  logic [CNT_W-1:0] count;
  logic             wr_prev;

  logic             wr;
  logic             accept;
  logic [REG_W-1:0] loaded;

  // Only the first cycle of a write burst is taken, so RMW dummy writes drop out.
  assign wr     = romsel & ~cpu_rw;
  assign accept = wr & ~wr_prev;
  assign loaded = {cpu_data_i[0], shift[4:1]};

  // Serial port, register file and write-edge history.
  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      control <= 5'h0C;
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
      shift   <= '0;
      count   <= '0;
      wr_prev <= 1'b0;
    end else begin
      wr_prev <= wr;
      if (accept) begin
        if (cpu_data_i[7]) begin
          shift        <= '0;
          count        <= '0;
          control[3:2] <= 2'b11;
        end else if (count == CNT_W'(4)) begin
          unique case (cpu_addr[14:13])
            2'd0:    control <= loaded;
            2'd1:    chr0    <= loaded;
            2'd2:    chr1    <= loaded;
            default: prg     <= loaded;
          endcase
          shift <= '0;
          count <= '0;
        end else begin
          shift <= loaded;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  logic [3:0]         prg_bank;
  logic [PRG_NAT-1:0] prg_full;
  logic [CHR_NAT-1:0] chr_full;

  // PRG windowing: 32KB mode ignores p[0]; 16KB modes fix one half.
  always_comb begin
    prg_bank = 4'h0;
    prg_full = '0;
    unique case (control[3:2])
      2'd2: begin
        prg_bank = cpu_addr[14] ? prg[3:0] : 4'h0;
        prg_full = {prg_bank, cpu_addr[13:0]};
      end
      2'd3: begin
        prg_bank = cpu_addr[14] ? 4'hF : prg[3:0];
        prg_full = {prg_bank, cpu_addr[13:0]};
      end
      default: prg_full = {prg[3:1], cpu_addr[14:0]};
    endcase
  end

  // CHR windowing: one 8KB bank, or two independent 4KB banks.
  always_comb begin
    chr_full = '0;
    if (control[4]) begin
      chr_full = {(ppu_addr[12] ? chr1 : chr0), ppu_addr[11:0]};
    end else begin
      chr_full = {chr0[4:1], ppu_addr[12:0]};
    end
  end

  // Nametable mirroring select.
  always_comb begin
    ciram_a10 = 1'b0;
    unique case (control[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_addr[10];
      default: ciram_a10 = ppu_addr[11];
    endcase
  end

  assign prg_addr  = PRG_AW'(prg_full);
  assign chr_addr  = CHR_AW'(chr_full);
  assign prgram_en = ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg[4];
  assign regs_dbg  = {control, chr0, chr1, prg};

  // Bits that carry no banking information.
  logic unused_bits;
  assign unused_bits = ^{cpu_data_i[6:1], ppu_addr[13], shift[0]};

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper: directed table, corner sequences and
// a randomized run against a queue-based reference model.
module tb_mmc1_mapper;

  logic        clk_cpu;
  logic        rst;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic        cpu_rw;
  logic        romsel;
  logic [13:0] ppu_addr;
  logic [17:0] prg_addr;
  logic [16:0] chr_addr;
  logic        ciram_a10;
  logic        prgram_en;
  logic [19:0] regs_dbg;

  mmc1_mapper #(.PRG_AW(18), .CHR_AW(17)) dut (
    .clk_cpu   (clk_cpu),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_data_i(cpu_data_i),
    .cpu_rw    (cpu_rw),
    .romsel    (romsel),
    .ppu_addr  (ppu_addr),
    .prg_addr  (prg_addr),
    .chr_addr  (chr_addr),
    .ciram_a10 (ciram_a10),
    .prgram_en (prgram_en),
    .regs_dbg  (regs_dbg)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: register values plus the pending serial bits.
  int m_ctrl, m_chr0, m_chr1, m_prg;
  int m_bits[$];
  bit m_prev_wr;
  bit m_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the model registers and the current bus address.
  task automatic check_model();
    int p, mode, a, bank, e_prg, e_chr, pa, e_cir, e_en;
    if (!m_valid) return;
    p    = m_prg % 16;
    mode = (m_ctrl / 4) % 4;
    a    = int'(cpu_addr);
    pa   = int'(ppu_addr);
    if (mode < 2) e_prg = (p / 2) * 32768 + a;
    else begin
      if (mode == 2) bank = (a >= 16384) ? p : 0;
      else           bank = (a >= 16384) ? 15 : p;
      e_prg = bank * 16384 + a % 16384;
    end
    if ((m_ctrl / 16) % 2 == 0) e_chr = (m_chr0 / 2) * 8192 + pa % 8192;
    else e_chr = (((pa / 4096) % 2 == 1) ? m_chr1 : m_chr0) * 4096 + pa % 4096;
    case (m_ctrl % 4)
      0: e_cir = 0;
      1: e_cir = 1;
      2: e_cir = (pa / 1024) % 2;
      default: e_cir = (pa / 2048) % 2;
    endcase
    e_en = (!romsel && (a / 8192) == 3 && (m_prg / 16) % 2 == 0) ? 1 : 0;
    check("prg_addr", 32'(prg_addr), 32'(e_prg));
    check("chr_addr", 32'(chr_addr), 32'(e_chr));
    check("ciram_a10", 32'(ciram_a10), 32'(e_cir));
    check("prgram_en", 32'(prgram_en), 32'(e_en));
    check("regs_dbg", 32'(regs_dbg),
          32'(m_ctrl * 32768 + m_chr0 * 1024 + m_chr1 * 32 + m_prg));
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit wr;
    int v;
    if (rst) begin
      m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
      m_bits.delete();
      m_prev_wr = 0;
      m_valid = 1;
      return;
    end
    wr = romsel && !cpu_rw;
    if (wr && !m_prev_wr) begin
      if (cpu_data_i[7]) begin
        m_bits.delete();
        m_ctrl = m_ctrl | 12;
      end else begin
        m_bits.push_back(int'(cpu_data_i[0]));
        if (m_bits.size() == 5) begin
          v = 0;
          for (int i = 0; i < 5; i++) v += m_bits[i] << i;
          case (int'(cpu_addr) / 8192)
            0: m_ctrl = v;
            1: m_chr0 = v;
            2: m_chr1 = v;
            default: m_prg = v;
          endcase
          m_bits.delete();
        end
      end
    end
    m_prev_wr = wr;
  endtask

  // One bus cycle: drive on negedge, check mid-cycle, update model at posedge.
  task automatic drive(input logic [14:0] a, input logic [7:0] d, input logic rw,
                       input logic rs, input logic [13:0] pa, input logic r);
    @(negedge clk_cpu);
    cpu_addr = a; cpu_data_i = d; cpu_rw = rw; romsel = rs; ppu_addr = pa; rst = r;
    #1;
    check_model();
    @(posedge clk_cpu);
    model_step();
  endtask

  task automatic wr_cyc(input logic [14:0] a, input logic [7:0] d);
    drive(a, d, 1'b0, 1'b1, 14'h0, 1'b0);
  endtask

  task automatic idle();
    drive(15'h0000, 8'h00, 1'b1, 1'b0, 14'h0, 1'b0);
  endtask

  task automatic load5(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      wr_cyc(a, {7'b0, v[i]});
      idle();
    end
  endtask

  // Two-edge write where the second (dummy) cycle carries the opposite bit.
  task automatic pair(input logic [14:0] a, input logic b);
    wr_cyc(a, {7'b0, b});
    wr_cyc(a, {7'b0, ~b});
    idle();
  endtask

  typedef struct {
    logic [14:0] reg_a;
    logic [4:0]  val;
    logic [14:0] cpu_a;
    logic        rs;
    logic [13:0] ppu_a;
    logic [17:0] e_prg;
    logic [16:0] e_chr;
    logic        e_cir;
    logic        e_en;
    logic [19:0] e_regs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] d;
    tbl[0] = '{15'h6000, 5'h05, 15'h0123, 1'b1, 14'h0000, 18'h14123, 17'h00000, 1'b0, 1'b0, 20'h60005};
    tbl[1] = '{15'h0000, 5'h12, 15'h4567, 1'b1, 14'h0400, 18'h14567, 17'h00400, 1'b1, 1'b0, 20'h90005};
    tbl[2] = '{15'h4000, 5'h07, 15'h6000, 1'b0, 14'h1ABC, 18'h16000, 17'h07ABC, 1'b0, 1'b1, 20'h900E5};
    tbl[3] = '{15'h2000, 5'h0B, 15'h0000, 1'b1, 14'h0800, 18'h10000, 17'h0B800, 1'b0, 1'b0, 20'h92CE5};
    tbl[4] = '{15'h0000, 5'h03, 15'h7FFF, 1'b1, 14'h0800, 18'h17FFF, 17'h0A800, 1'b1, 1'b0, 20'h1ACE5};
    tbl[5] = '{15'h6000, 5'h1A, 15'h6000, 1'b0, 14'h0000, 18'h2E000, 17'h0A000, 1'b0, 1'b0, 20'h1ACFA};
    tbl[6] = '{15'h0000, 5'h09, 15'h4001, 1'b1, 14'h1FFF, 18'h28001, 17'h0BFFF, 1'b1, 1'b0, 20'h4ACFA};
    tbl[7] = '{15'h6000, 5'h00, 15'h0005, 1'b1, 14'h0000, 18'h00005, 17'h0A000, 1'b1, 1'b0, 20'h4ACE0};

    cpu_addr = '0; cpu_data_i = '0; cpu_rw = 1'b1; romsel = 1'b0; ppu_addr = '0; rst = 1'b1;

    // Reset, then one more reset cycle with a bank-F probe.
    drive(15'h0000, 8'h00, 1'b1, 1'b0, 14'h0, 1'b1);
    drive(15'h4000, 8'h00, 1'b1, 1'b1, 14'h0, 1'b1);
    @(negedge clk_cpu);
    cpu_addr = 15'h4000; romsel = 1'b1; cpu_rw = 1'b1; rst = 1'b0;
    #1;
    check("reset_regs", 32'(regs_dbg), 32'h60000);
    check("reset_prg_addr", 32'(prg_addr), 32'h3C000);
    @(posedge clk_cpu);
    model_step();

    // Directed table: serial load then a probe against fixed expectations.
    for (int t = 0; t < 8; t++) begin
      load5(tbl[t].reg_a, tbl[t].val);
      @(negedge clk_cpu);
      cpu_addr = tbl[t].cpu_a; cpu_data_i = 8'h00; cpu_rw = 1'b1;
      romsel = tbl[t].rs; ppu_addr = tbl[t].ppu_a; rst = 1'b0;
      #1;
      check_model();
      check($sformatf("tbl%0d_prg", t), 32'(prg_addr), 32'(tbl[t].e_prg));
      check($sformatf("tbl%0d_chr", t), 32'(chr_addr), 32'(tbl[t].e_chr));
      check($sformatf("tbl%0d_ciram", t), 32'(ciram_a10), 32'(tbl[t].e_cir));
      check($sformatf("tbl%0d_prgram", t), 32'(prgram_en), 32'(tbl[t].e_en));
      check($sformatf("tbl%0d_regs", t), 32'(regs_dbg), 32'(tbl[t].e_regs));
      @(posedge clk_cpu);
      model_step();
    end

    // Reset mid-sequence, with a write in the same cycle, discards partial bits.
    wr_cyc(15'h6000, 8'h01); idle();
    wr_cyc(15'h6000, 8'h01); idle();
    wr_cyc(15'h6000, 8'h01); idle();
    drive(15'h6000, 8'h01, 1'b0, 1'b1, 14'h0, 1'b1);
    idle();
    load5(15'h6000, 5'h02);
    idle();
    check("rst_mid_seq", 32'(regs_dbg), 32'h60002);

    // Bit-7 write after three bits resets the port and forces control[3:2].
    load5(15'h0000, 5'h00);
    idle();
    check("ctrl_zero", 32'(regs_dbg), 32'h00002);
    wr_cyc(15'h0000, 8'h01); idle();
    wr_cyc(15'h0000, 8'h01); idle();
    wr_cyc(15'h0000, 8'h01); idle();
    wr_cyc(15'h0000, 8'h80); idle();
    check("bit7_reset", 32'(regs_dbg), 32'h60002);
    load5(15'h6000, 5'h11);
    idle();
    check("after_bit7_load", 32'(regs_dbg), 32'h60011);

    // Back-to-back write pairs count once: 10 pairs load prg then chr1.
    for (int i = 0; i < 5; i++) begin
      logic [4:0] v;
      v = 5'h16;
      pair(15'h6000, v[i]);
    end
    for (int i = 0; i < 5; i++) begin
      logic [4:0] v;
      v = 5'h09;
      pair(15'h4000, v[i]);
    end
    idle();
    check("b2b_pairs", 32'(regs_dbg), 32'h60136);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      d = 8'($urandom);
      if ($urandom_range(9) != 0) d[7] = 1'b0;
      drive(15'($urandom), d, 1'($urandom), 1'($urandom), 14'($urandom),
            ($urandom_range(127) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
